// File: rtl/red_pitaya_hk_gpio.sv
// Housekeeping slave: ID and LED registers with heartbeat, plus a GPIO expansion
// bank with synchronised inputs, per-pin edge detection, sticky W1C status and IRQ.
module red_pitaya_hk_gpio #(
  parameter int          GPIO_W    = 8,
  parameter int          LED_W     = 8,
  parameter int          BLINK_BIT = 26,
  parameter logic [31:0] ID_VALUE  = 32'h00000002
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  output logic [LED_W-1:0]  led_o,
  input  logic [GPIO_W-1:0] exp_p_dat_i,
  output logic [GPIO_W-1:0] exp_p_dat_o,
  output logic [GPIO_W-1:0] exp_p_dir_o,
  input  logic [GPIO_W-1:0] exp_n_dat_i,
  output logic [GPIO_W-1:0] exp_n_dat_o,
  output logic [GPIO_W-1:0] exp_n_dir_o,
  output logic              irq_o,
  input  logic [31:0]       sys_addr,
  input  logic [31:0]       sys_wdata,
  input  logic [3:0]        sys_sel,
  input  logic              sys_wen,
  input  logic              sys_ren,
  output logic [31:0]       sys_rdata,
  output logic              sys_err,
  output logic              sys_ack
);

  localparam logic [19:0] A_ID     = 20'h00000;
  localparam logic [19:0] A_DIR    = 20'h00010;
  localparam logic [19:0] A_OUT    = 20'h00014;
  localparam logic [19:0] A_IN     = 20'h00018;
  localparam logic [19:0] A_RISE   = 20'h0001C;
  localparam logic [19:0] A_FALL   = 20'h00020;
  localparam logic [19:0] A_STATUS = 20'h00024;
  localparam logic [19:0] A_IRQEN  = 20'h00028;
  localparam logic [19:0] A_LED    = 20'h00030;

  // Only 16 pins per bank fit the register layout (p at bit 0, n at bit 16).
  localparam int          GW16      = (GPIO_W > 16) ? 16 : GPIO_W;
  localparam logic [31:0] BANK_MASK = (32'd1 << GW16) - 32'd1;
  localparam logic [31:0] GPIO_MASK = BANK_MASK | (BANK_MASK << 16);
  localparam logic [31:0] LED_MASK  = ((32'd1 << LED_W) - 32'd1) & ~32'd1;

  logic [31:0] r_dir, r_out, r_rise_en, r_fall_en, r_status, r_irq_en, r_led;
  logic [31:0] r_sync1, r_sync2, r_hist, r_cnt, r_rdata;
  logic [1:0]  r_prime;
  logic        r_ack, r_irq;

  logic [31:0] w_pins, w_wmask, w_clr, w_rise, w_fall, w_rdata;
  logic [19:0] w_addr;
  logic        w_armed;
  logic        w_unused;

  assign w_addr  = sys_addr[19:0];
  assign w_wmask = {{8{sys_sel[3]}}, {8{sys_sel[2]}}, {8{sys_sel[1]}}, {8{sys_sel[0]}}};
  assign w_clr   = (sys_wen && w_addr == A_STATUS) ? (sys_wdata & w_wmask) : 32'd0;
  assign w_armed = (r_prime == 2'd3);
  assign w_rise  = w_armed ? ( r_sync2 & ~r_hist & r_rise_en) : 32'd0;
  assign w_fall  = w_armed ? (~r_sync2 &  r_hist & r_fall_en) : 32'd0;
  assign w_unused = ^{sys_addr[31:20], r_cnt};

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pin_in
      if (gi < GPIO_W) begin : g_used
        assign w_pins[gi]      = exp_p_dat_i[gi];
        assign w_pins[gi + 16] = exp_n_dat_i[gi];
      end else begin : g_spare
        assign w_pins[gi]      = 1'b0;
        assign w_pins[gi + 16] = 1'b0;
      end
    end
    for (gi = 0; gi < GPIO_W; gi++) begin : g_pin_out
      if (gi < 16) begin : g_mapped
        assign exp_p_dat_o[gi] = r_out[gi];
        assign exp_n_dat_o[gi] = r_out[gi + 16];
        assign exp_p_dir_o[gi] = r_dir[gi];
        assign exp_n_dir_o[gi] = r_dir[gi + 16];
      end else begin : g_unmapped
        assign exp_p_dat_o[gi] = 1'b0;
        assign exp_n_dat_o[gi] = 1'b0;
        assign exp_p_dir_o[gi] = 1'b0;
        assign exp_n_dir_o[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    w_rdata = 32'd0;
    case (w_addr)
      A_ID:     w_rdata = ID_VALUE;
      A_DIR:    w_rdata = r_dir;
      A_OUT:    w_rdata = r_out;
      A_IN:     w_rdata = r_sync2;
      A_RISE:   w_rdata = r_rise_en;
      A_FALL:   w_rdata = r_fall_en;
      A_STATUS: w_rdata = r_status;
      A_IRQEN:  w_rdata = r_irq_en;
      A_LED:    w_rdata = r_led;
      default:  w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_dir     <= 32'd0;
      r_out     <= 32'd0;
      r_rise_en <= 32'd0;
      r_fall_en <= 32'd0;
      r_irq_en  <= 32'd0;
      r_led     <= 32'd0;
      r_ack     <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      r_ack <= sys_wen | sys_ren;
      if (sys_ren)
        r_rdata <= w_rdata;
      if (sys_wen) begin
        case (w_addr)
          A_DIR:   r_dir     <= (r_dir     & ~w_wmask) | (sys_wdata & w_wmask & GPIO_MASK);
          A_OUT:   r_out     <= (r_out     & ~w_wmask) | (sys_wdata & w_wmask & GPIO_MASK);
          A_RISE:  r_rise_en <= (r_rise_en & ~w_wmask) | (sys_wdata & w_wmask & GPIO_MASK);
          A_FALL:  r_fall_en <= (r_fall_en & ~w_wmask) | (sys_wdata & w_wmask & GPIO_MASK);
          A_IRQEN: r_irq_en  <= (r_irq_en  & ~w_wmask) | (sys_wdata & w_wmask & GPIO_MASK);
          A_LED:   r_led     <= (r_led     & ~w_wmask) | (sys_wdata & w_wmask & LED_MASK);
          default: ;
        endcase
      end
    end
  end

  // Input path: two-flop synchroniser, then history for edge detection.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_sync1  <= 32'd0;
      r_sync2  <= 32'd0;
      r_hist   <= 32'd0;
      r_prime  <= 2'd0;
      r_status <= 32'd0;
      r_irq    <= 1'b0;
      r_cnt    <= 32'd0;
    end else begin
      r_sync1  <= w_pins;
      r_sync2  <= r_sync1;
      r_hist   <= r_sync2;
      if (!w_armed)
        r_prime <= r_prime + 2'd1;
      // A new event on the same cycle as its W1C wins.
      r_status <= (r_status & ~w_clr) | w_rise | w_fall;
      r_irq    <= |(r_status & r_irq_en);
      r_cnt    <= r_cnt + 32'd1;
    end
  end

  assign led_o     = {r_led[LED_W-1:1], r_cnt[BLINK_BIT]};
  assign irq_o     = r_irq;
  assign sys_ack   = r_ack;
  assign sys_rdata = r_rdata;
  assign sys_err   = 1'b0;

endmodule

// File: tb/tb_red_pitaya_hk_gpio.sv
// Self-checking bench for red_pitaya_hk_gpio: directed scenarios plus randomized
// edge/status traffic compared against a register-level behavioural model.
module tb_red_pitaya_hk_gpio;
  localparam int          GPIO_W    = 8;
  localparam int          LED_W     = 8;
  localparam int          BLINK_BIT = 4;
  localparam logic [31:0] ID_VALUE  = 32'h0000_0002;
  localparam logic [31:0] GMASK     = 32'h00FF_00FF;

  logic              clk = 1'b0;
  logic              rstn;
  logic [LED_W-1:0]  led;
  logic [GPIO_W-1:0] p_in, p_dat, p_dir, n_in, n_dat, n_dir;
  logic              irq;
  logic [31:0]       addr, wdata, rdata;
  logic [3:0]        sel;
  logic              wen, ren, err, ack;
  int                checks = 0;
  int                failures = 0;
  bit                wr_ack_ok;

  always #5 clk = ~clk;

  red_pitaya_hk_gpio #(
    .GPIO_W(GPIO_W), .LED_W(LED_W), .BLINK_BIT(BLINK_BIT), .ID_VALUE(ID_VALUE)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .led_o(led),
    .exp_p_dat_i(p_in), .exp_p_dat_o(p_dat), .exp_p_dir_o(p_dir),
    .exp_n_dat_i(n_in), .exp_n_dat_o(n_dat), .exp_n_dir_o(n_dir),
    .irq_o(irq), .sys_addr(addr), .sys_wdata(wdata), .sys_sel(sel),
    .sys_wen(wen), .sys_ren(ren), .sys_rdata(rdata), .sys_err(err), .sys_ack(ack)
  );

  function automatic logic [31:0] pack(input logic [7:0] p, input logic [7:0] n);
    return {8'h00, n, 8'h00, p};
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // All bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    addr = a; wdata = d; sel = s; wen = 1'b1;
    @(negedge clk);
    wr_ack_ok = (ack === 1'b1);
    wen = 1'b0;
    @(negedge clk);
    wr_ack_ok = wr_ack_ok && (ack === 1'b0);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output bit ok);
    addr = a; ren = 1'b1;
    @(negedge clk);
    ok = (ack === 1'b1);
    d = rdata;
    ren = 1'b0;
    @(negedge clk);
    ok = ok && (ack === 1'b0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bit ok;
    p_in = '0; n_in = '0; addr = '0; wdata = '0; sel = '0; wen = 1'b0; ren = 1'b0;
    do_reset();
    checks++;
    if ({led, p_dat, p_dir, n_dat, n_dir, irq, ack, err} !== '0 || rdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: got led=%h pdat=%h pdir=%h ndat=%h ndir=%h irq=%b ack=%b err=%b rdata=%h required all 0",
               led, p_dat, p_dir, n_dat, n_dir, irq, ack, err, rdata);
    end
    bus_read(32'h0, d, ok);
    checks++;
    if (d !== ID_VALUE || !ok) begin
      failures++; $display("FAIL id_read: got %h ack_ok=%b required %h ack_ok=1", d, ok, ID_VALUE);
    end
    bus_read(32'h3FC, d, ok);
    checks++;
    if (d !== 32'd0 || !ok) begin
      failures++; $display("FAIL unmapped_read: got %h ack_ok=%b required 0 ack_ok=1", d, ok);
    end
    bus_read(32'h24, d, ok);
    checks++;
    if (d !== 32'd0) begin
      failures++; $display("FAIL reset_status: got %h required 0", d);
    end
  endtask

  task automatic test_dir();
    logic [31:0] d;
    bit ok;
    bus_write(32'h10, 32'h00A5_00FF, 4'b0001);
    checks++;
    if (p_dir !== 8'hFF || n_dir !== 8'h00 || !wr_ack_ok) begin
      failures++; $display("FAIL dir_sel0: got p=%h n=%h ack_ok=%b required p=ff n=00 ack_ok=1", p_dir, n_dir, wr_ack_ok);
    end
    bus_write(32'h10, 32'h00A5_0000, 4'b0100);
    checks++;
    if (p_dir !== 8'hFF || n_dir !== 8'hA5) begin
      failures++; $display("FAIL dir_sel2: got p=%h n=%h required p=ff n=a5", p_dir, n_dir);
    end
    bus_write(32'h2C, 32'hFFFF_FFFF, 4'hF);
    bus_read(32'h10, d, ok);
    checks++;
    if (d !== 32'h00A5_00FF) begin
      failures++; $display("FAIL dir_readback: got %h required 00a500ff", d);
    end
    bus_write(32'h14, 32'h123C_45C3, 4'hF);
    checks++;
    if (p_dat !== 8'hC3 || n_dat !== 8'h3C || rdata !== 32'h00A5_00FF) begin
      failures++; $display("FAIL out_write: got p=%h n=%h rdata=%h required p=c3 n=3c rdata=00a500ff", p_dat, n_dat, rdata);
    end
  endtask

  task automatic test_edge_timing();
    logic [31:0] d;
    bit ok;
    logic [31:0] exp_rd [3] = '{32'd0, 32'd0, 32'd1};
    logic        exp_irq [3] = '{1'b0, 1'b0, 1'b1};
    bus_write(32'h1C, 32'h1, 4'hF);
    bus_write(32'h20, 32'h0, 4'hF);
    bus_write(32'h28, 32'h1, 4'hF);
    bus_write(32'h24, 32'hFFFF_FFFF, 4'hF);
    p_in = 8'h01;                       // sampled at edge k
    @(negedge clk);
    addr = 32'h24; ren = 1'b1;
    for (int i = 0; i < 3; i++) begin   // observe after edges k+1, k+2, k+3
      @(negedge clk);
      checks++;
      if (rdata !== exp_rd[i] || irq !== exp_irq[i] || ack !== 1'b1) begin
        failures++; $display("FAIL rise_timing_k%0d: got status=%h irq=%b ack=%b required status=%h irq=%b ack=1",
                             i + 1, rdata, irq, ack, exp_rd[i], exp_irq[i]);
      end
    end
    ren = 1'b0;
    p_in = 8'h03;
    @(negedge clk);
    addr = 32'h18; ren = 1'b1;
    @(negedge clk);
    checks++;
    if (rdata !== 32'h1) begin
      failures++; $display("FAIL in_timing_k1: got %h required 00000001", rdata);
    end
    @(negedge clk);
    checks++;
    if (rdata !== 32'h3) begin
      failures++; $display("FAIL in_timing_k2: got %h required 00000003", rdata);
    end
    ren = 1'b0;
    addr = 32'h24; wdata = 32'h1; sel = 4'b0001; wen = 1'b1;
    @(negedge clk);
    wen = 1'b0;
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("FAIL irq_hold_at_clear: got %b required 1", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_drop_after_clear: got %b required 0", irq);
    end
    bus_read(32'h24, d, ok);
    checks++;
    if (d !== 32'd0) begin
      failures++; $display("FAIL status_cleared: got %h required 0", d);
    end
    p_in = 8'h00; repeat (4) @(negedge clk);
    p_in = 8'h01; repeat (5) @(negedge clk);
    bus_write(32'h28, 32'h0, 4'hF);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_en_clear: got %b required 0", irq);
    end
    bus_write(32'h1C, 32'h0, 4'hF);
    bus_read(32'h24, d, ok);
    checks++;
    if (d !== 32'h1) begin
      failures++; $display("FAIL status_kept: got %h required 00000001", d);
    end
    bus_write(32'h24, 32'hFFFF_FFFF, 4'hF);
  endtask

  task automatic test_same_cycle();
    logic [31:0] d;
    bit ok;
    n_in = 8'h08; repeat (5) @(negedge clk);
    bus_write(32'h24, 32'hFFFF_FFFF, 4'hF);
    bus_write(32'h20, 32'h0008_0000, 4'hF);
    n_in = 8'h00;                       // sampled at edge k, status sets at k+2
    repeat (2) @(negedge clk);
    bus_write(32'h24, 32'h0008_0000, 4'b0100);
    bus_read(32'h24, d, ok);
    checks++;
    if (d !== 32'h0008_0000) begin
      failures++; $display("FAIL set_beats_clear: got %h required 00080000", d);
    end
    bus_write(32'h24, 32'h0008_0000, 4'b1011);
    bus_read(32'h24, d, ok);
    checks++;
    if (d !== 32'h0008_0000) begin
      failures++; $display("FAIL w1c_deselected: got %h required 00080000", d);
    end
    bus_write(32'h24, 32'h0008_0000, 4'b0100);
    bus_read(32'h24, d, ok);
    checks++;
    if (d !== 32'd0) begin
      failures++; $display("FAIL w1c_selected: got %h required 0", d);
    end
    bus_write(32'h20, 32'h0, 4'hF);
  endtask

  task automatic test_random();
    logic [31:0] d, m_status, m_rise, m_fall, m_irqen, m_pins, m_new, w, bm;
    logic [3:0]  s;
    bit ok;
    bus_write(32'h24, 32'hFFFF_FFFF, 4'hF);
    m_status = 32'd0; m_rise = 32'd0; m_fall = 32'd0; m_irqen = 32'd0;
    m_pins = pack(p_in, n_in);
    for (int it = 0; it < 20; it++) begin
      w = $urandom; s = 4'($urandom_range(0, 15)); bm = byte_mask(s);
      bus_write(32'h1C, w, s); m_rise  = (m_rise  & ~bm) | (w & bm & GMASK);
      w = $urandom; s = 4'($urandom_range(0, 15)); bm = byte_mask(s);
      bus_write(32'h20, w, s); m_fall  = (m_fall  & ~bm) | (w & bm & GMASK);
      w = $urandom; s = 4'($urandom_range(0, 15)); bm = byte_mask(s);
      bus_write(32'h28, w, s); m_irqen = (m_irqen & ~bm) | (w & bm & GMASK);
      p_in = 8'($urandom); n_in = 8'($urandom);
      m_new = pack(p_in, n_in);
      m_status = m_status | (m_new & ~m_pins & m_rise) | (~m_new & m_pins & m_fall);
      m_pins = m_new;
      repeat (5) @(negedge clk);
      bus_read(32'h18, d, ok);
      checks++;
      if (d !== m_pins) begin
        failures++; $display("FAIL rand_in[%0d]: got %h required %h", it, d, m_pins);
      end
      bus_read(32'h24, d, ok);
      checks++;
      if (d !== m_status || irq !== |(m_status & m_irqen)) begin
        failures++; $display("FAIL rand_status[%0d]: got %h irq=%b required %h irq=%b",
                             it, d, irq, m_status, |(m_status & m_irqen));
      end
      w = $urandom; s = 4'($urandom_range(0, 15));
      bus_write(32'h24, w, s);
      m_status = m_status & ~(w & byte_mask(s));
      bus_read(32'h24, d, ok);
      checks++;
      if (d !== m_status) begin
        failures++; $display("FAIL rand_w1c[%0d]: got %h required %h", it, d, m_status);
      end
    end
    bus_write(32'h1C, 32'h0, 4'hF);
    bus_write(32'h20, 32'h0, 4'hF);
    bus_write(32'h28, 32'h0, 4'hF);
  endtask

  task automatic test_led();
    logic [31:0] d;
    bit ok;
    logic prev;
    int last, ntog;
    bus_write(32'h30, 32'hFF, 4'hF);
    bus_read(32'h30, d, ok);
    checks++;
    if (d !== 32'hFE) begin
      failures++; $display("FAIL led_readback: got %h required 000000fe", d);
    end
    bus_write(32'h30, 32'hFE, 4'hF);
    checks++;
    if (led[7:1] !== 7'h7F) begin
      failures++; $display("FAIL led_bits: got %h required 7f", led[7:1]);
    end
    prev = led[0]; last = -1; ntog = 0;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (led[0] !== prev) begin
        if (last >= 0) begin
          checks++;
          if (c - last != 16) begin
            failures++; $display("FAIL blink_period: got %0d required 16", c - last);
          end
        end
        last = c; ntog++; prev = led[0];
      end
    end
    checks++;
    if (ntog < 6) begin
      failures++; $display("FAIL blink_toggles: got %0d required >=6", ntog);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] d;
    bit ok;
    bus_write(32'h10, 32'h0000_000F, 4'hF);
    addr = 32'h10; wdata = 32'hFF; sel = 4'hF; wen = 1'b1; rstn = 1'b0;
    @(negedge clk);
    wen = 1'b0;
    checks++;
    if (ack !== 1'b0 || p_dir !== 8'h00 || led !== '0) begin
      failures++; $display("FAIL reset_mid_access: got ack=%b pdir=%h led=%h required 0 00 00", ack, p_dir, led);
    end
    @(negedge clk);
    rstn = 1'b1;
    bus_read(32'h10, d, ok);
    checks++;
    if (d !== 32'd0) begin
      failures++; $display("FAIL dir_after_reset: got %h required 0", d);
    end
  endtask

  task automatic test_priming();
    logic [31:0] d;
    bit ok;
    p_in = 8'hFF; n_in = 8'hFF;
    do_reset();
    bus_write(32'h1C, 32'h00FF_00FF, 4'hF);
    bus_write(32'h28, 32'h00FF_00FF, 4'hF);
    repeat (6) @(negedge clk);
    bus_read(32'h24, d, ok);
    checks++;
    if (d !== 32'd0 || irq !== 1'b0) begin
      failures++; $display("FAIL priming_status: got %h irq=%b required 0 irq=0", d, irq);
    end
    bus_read(32'h18, d, ok);
    checks++;
    if (d !== 32'h00FF_00FF) begin
      failures++; $display("FAIL priming_in: got %h required 00ff00ff", d);
    end
  endtask

  initial begin
    test_reset();
    test_dir();
    test_edge_timing();
    test_same_cycle();
    test_random();
    test_led();
    test_reset_mid_access();
    test_priming();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
